// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared types and constants for the UART-to-SDRAM load path
package load_pkg;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_DONE
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 4;

endpackage

// File: rtl/audio_word_fifo.sv
// rtl/audio_word_fifo.sv - first-word-fall-through word FIFO with same-cycle push/pop
module audio_word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/rs232_audio_receiver.sv
// rtl/rs232_audio_receiver.sv - parses word-count header and packs UART bytes into 32-bit words
module rs232_audio_receiver
    import load_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 23
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_byte,
    output logic             o_word_valid,
    output logic [31:0]      o_word_data,
    output logic             o_word_last,
    input  logic             i_word_ready,
    output logic             o_rx_done,
    output logic             o_overflow,
    output logic             o_count_err,
    output logic [CNT_W-1:0] o_words_left
);

    localparam logic [31:0] MAX_COUNT = 32'd1 << CNT_W;

    rx_state_t      state;
    rx_state_t      state_nxt;
    logic [1:0]     hdr_idx;
    logic [1:0]     byte_idx;
    logic [23:0]    hdr_shift;
    logic [23:0]    lanes;
    logic [31:0]    hdr_full;
    logic [CNT_W:0] total;
    logic [CNT_W:0] push_cnt;
    logic [CNT_W:0] words_left;
    logic           hdr_take;
    logic           count_zero;
    logic           count_big;
    logic           byte_take;
    logic           word_done;
    logic           pop;
    logic           push;
    logic           push_ok;
    logic           last_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [32:0]    fifo_head;
    logic [32:0]    push_word;

    assign hdr_full   = {i_rx_byte, hdr_shift};
    assign hdr_take   = (state == S_HDR) && i_rx_valid && (hdr_idx == 2'(HDR_BYTES - 1));
    assign count_zero = (hdr_full == 32'd0);
    assign count_big  = (hdr_full > MAX_COUNT);

    // Bytes beyond the announced word count are silently ignored.
    assign byte_take = (state == S_DATA) && (push_cnt < total) && i_rx_valid;
    assign word_done = byte_take && (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign pop       = o_word_valid && i_word_ready;
    assign push_ok   = !fifo_full || pop;
    assign push      = word_done && push_ok;
    assign last_pop  = pop && (words_left == (CNT_W+1)'(1));
    assign push_word = {(push_cnt + (CNT_W+1)'(1)) == total, i_rx_byte, lanes};

    audio_word_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (push_word),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_HDR;
        else       state <= state_nxt;
    end

    // Next state: header decides between data phase and immediate completion.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR:   if (hdr_take) state_nxt = (count_zero || count_big) ? S_DONE : S_DATA;
            S_DATA:  if (last_pop) state_nxt = S_DONE;
            default: state_nxt = S_DONE;
        endcase
    end

    // Outputs: data is only presented during the data phase and masked to zero otherwise.
    always_comb begin
        o_word_valid = (state == S_DATA) && !fifo_empty;
        o_word_data  = o_word_valid ? fifo_head[31:0] : 32'd0;
        o_word_last  = o_word_valid && fifo_head[32];
        o_rx_done    = (state == S_DONE) && !o_count_err;
        o_words_left = words_left[CNT_W] ? '1 : words_left[CNT_W-1:0];
    end

    // Header assembly, byte packing, counters and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hdr_idx     <= '0;
            hdr_shift   <= '0;
            byte_idx    <= '0;
            lanes       <= '0;
            total       <= '0;
            push_cnt    <= '0;
            words_left  <= '0;
            o_overflow  <= 1'b0;
            o_count_err <= 1'b0;
        end else begin
            if ((state == S_HDR) && i_rx_valid) begin
                hdr_shift <= {i_rx_byte, hdr_shift[23:8]};
                hdr_idx   <= hdr_idx + 2'd1;
            end
            if (hdr_take) begin
                if (count_big) begin
                    o_count_err <= 1'b1;
                end else if (!count_zero) begin
                    total      <= hdr_full[CNT_W:0];
                    words_left <= hdr_full[CNT_W:0];
                end
            end
            if (byte_take) begin
                if (!word_done) begin
                    lanes    <= {i_rx_byte, lanes[23:8]};
                    byte_idx <= byte_idx + 2'd1;
                end else if (push_ok) begin
                    byte_idx <= '0;
                    push_cnt <= push_cnt + (CNT_W+1)'(1);
                end else begin
                    o_overflow <= 1'b1;
                end
            end
            if (pop) words_left <= words_left - (CNT_W+1)'(1);
        end
    end

endmodule
